// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter with burst limit, driving a shared 2:1 mux
// into a one-entry registered output stage.
module mux2_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_req_valid,
    input  logic [DATA_W-1:0] i_req_data0,
    input  logic [DATA_W-1:0] i_req_data1,
    output logic [1:0]        o_req_ready,
    output logic              o_sel,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_src,
    input  logic              i_out_ready
);
    localparam int CW = $clog2(BURST_MAX + 1);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_last, w_last_nxt;
    logic              r_sel, w_sel_nxt;
    logic              r_out_valid, r_out_src;
    logic [DATA_W-1:0] r_out_data;
    logic              w_k, w_space, w_own, w_other, w_acc, w_burst_end;
    always_comb begin
        w_k         = r_state == GNT1;
        w_space     = ~r_out_valid | i_out_ready;
        o_req_ready = {2{w_space}} & {r_state == GNT1, r_state == GNT0};
        w_own       = i_req_valid[w_k];
        w_other     = i_req_valid[~w_k];
        w_acc       = |(i_req_valid & o_req_ready);
        w_cnt_inc   = r_cnt + CW'(1);
        w_burst_end = w_acc && (w_cnt_inc == CW'(BURST_MAX));
        w_state_nxt = r_state;
        w_cnt_nxt   = w_acc ? w_cnt_inc : r_cnt;
        w_last_nxt  = r_last;
        if (r_state == IDLE) begin
            w_state_nxt = i_req_valid == 2'b11 ? (r_last ? GNT0 : GNT1) :
                          i_req_valid[1] ? GNT1 : i_req_valid[0] ? GNT0 : IDLE;
        end else if (!w_own || (w_burst_end && w_other)) begin
            // Hand over directly to a waiting peer, otherwise fall back to IDLE
            w_state_nxt = w_other ? (w_k ? GNT0 : GNT1) : IDLE;
            w_last_nxt  = w_k;
            w_cnt_nxt   = '0;
        end else if (w_burst_end) begin
            w_cnt_nxt = '0;
        end
        w_sel_nxt = w_state_nxt == IDLE ? r_sel : w_state_nxt == GNT1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            if (w_acc) begin
                r_out_data  <= r_sel ? i_req_data1 : i_req_data0;
                r_out_src   <= w_k;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
    assign o_sel       = r_sel;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_src   = r_out_src;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vector table plus hand-written sequences for the arbiter.
module tb_mux2_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b11;
    logic [7:0] d0 = '0, d1 = '0;
    logic [1:0] req_ready;
    logic       sel, out_valid, out_src;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    int         checks = 0, errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic [7:0] a, b;
        logic       ordy;
        logic [1:0] rr;
        logic       sel, ov;
        logic [7:0] od;
        logic       os;
    } vec_t;
    vec_t vq[$];

    mux2_rr_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data0(d0), .i_req_data1(d1),
        .o_req_ready(req_ready), .o_sel(sel), .o_out_valid(out_valid), .o_out_data(out_data),
        .o_out_src(out_src), .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] rv, input logic [7:0] a, b, input logic o,
                       input logic [1:0] rr, input logic s, ov, input logic [7:0] od, input logic os);
        vec_t v;
        v.rst = r; v.rv = rv; v.a = a; v.b = b; v.ordy = o;
        v.rr = rr; v.sel = s; v.ov = ov; v.od = od; v.os = os;
        vq.push_back(v);
    endtask

    task automatic step(input logic r, input logic [1:0] rv, input logic [7:0] a, b, input logic o);
        @(negedge clk);
        rst = r; req_valid = rv; d0 = a; d1 = b; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] rr, input logic s, ov,
                         input logic [7:0] od, input logic os);
        checks++;
        if ({req_ready, sel, out_valid, out_data, out_src} !== {rr, s, ov, od, os}) begin
            errors++;
            $display("FAIL %s: got rr=%b sel=%b ov=%b od=%h os=%b, expected rr=%b sel=%b ov=%b od=%h os=%b",
                     name, req_ready, sel, out_valid, out_data, out_src, rr, s, ov, od, os);
        end
    endtask

    initial begin
        // reset with both requesting, then release: req0 wins the first tie
        add(1, 2'b11, 8'h00, 8'h80, 1, 2'b00, 0, 0, 8'h00, 0);
        add(1, 2'b11, 8'h00, 8'h80, 1, 2'b00, 0, 0, 8'h00, 0);
        add(0, 2'b11, 8'h00, 8'h80, 1, 2'b01, 0, 0, 8'h00, 0);
        // contention: bursts of four, direct grant switch
        add(0, 2'b11, 8'h00, 8'h80, 1, 2'b01, 0, 1, 8'h00, 0);
        add(0, 2'b11, 8'h01, 8'h80, 1, 2'b01, 0, 1, 8'h01, 0);
        add(0, 2'b11, 8'h02, 8'h80, 1, 2'b01, 0, 1, 8'h02, 0);
        add(0, 2'b11, 8'h03, 8'h80, 1, 2'b10, 1, 1, 8'h03, 0);
        add(0, 2'b11, 8'h04, 8'h80, 1, 2'b10, 1, 1, 8'h80, 1);
        add(0, 2'b11, 8'h04, 8'h81, 1, 2'b10, 1, 1, 8'h81, 1);
        add(0, 2'b11, 8'h04, 8'h82, 1, 2'b10, 1, 1, 8'h82, 1);
        add(0, 2'b11, 8'h04, 8'h83, 1, 2'b01, 0, 1, 8'h83, 1);
        add(0, 2'b11, 8'h04, 8'h84, 1, 2'b01, 0, 1, 8'h04, 0);
        // backpressure: held beat stable, no accept, then pop+accept together
        add(0, 2'b11, 8'h05, 8'h84, 0, 2'b00, 0, 1, 8'h04, 0);
        add(0, 2'b11, 8'h05, 8'h84, 0, 2'b00, 0, 1, 8'h04, 0);
        add(0, 2'b11, 8'h05, 8'h84, 0, 2'b00, 0, 1, 8'h04, 0);
        add(0, 2'b11, 8'h05, 8'h84, 1, 2'b01, 0, 1, 8'h05, 0);
        // early release: req0 drops, req1 takes two beats then drops
        add(0, 2'b10, 8'h05, 8'h84, 1, 2'b10, 1, 0, 8'h05, 0);
        add(0, 2'b10, 8'h06, 8'h84, 1, 2'b10, 1, 1, 8'h84, 1);
        add(0, 2'b11, 8'h06, 8'h85, 1, 2'b10, 1, 1, 8'h85, 1);
        add(0, 2'b01, 8'h06, 8'h86, 1, 2'b01, 0, 0, 8'h85, 1);
        // a full burst of four proves the count restarted at zero
        add(0, 2'b11, 8'h06, 8'h86, 1, 2'b01, 0, 1, 8'h06, 0);
        add(0, 2'b11, 8'h07, 8'h86, 1, 2'b01, 0, 1, 8'h07, 0);
        add(0, 2'b11, 8'h08, 8'h86, 1, 2'b01, 0, 1, 8'h08, 0);
        add(0, 2'b11, 8'h09, 8'h86, 1, 2'b10, 1, 1, 8'h09, 0);
        // both idle -> IDLE (sel held), then tie goes to req0
        add(0, 2'b10, 8'h0A, 8'h86, 1, 2'b10, 1, 1, 8'h86, 1);
        add(0, 2'b00, 8'h0A, 8'h87, 1, 2'b00, 1, 0, 8'h86, 1);
        add(0, 2'b11, 8'h0A, 8'h87, 1, 2'b01, 0, 0, 8'h86, 1);
        add(0, 2'b11, 8'h0A, 8'h87, 1, 2'b01, 0, 1, 8'h0A, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].rv, vq[i].a, vq[i].b, vq[i].ordy);
            check($sformatf("vec%0d", i), vq[i].rr, vq[i].sel, vq[i].ov, vq[i].od, vq[i].os);
        end

        // single requester streams six beats gap-free, across the burst limit
        for (int i = 0; i < 6; i++) begin
            step(0, 2'b01, 8'h10 + 8'(i), 8'h87, 1);
            check($sformatf("stream%0d", i), 2'b01, 0, 1, 8'h10 + 8'(i), 0);
        end
        step(0, 2'b00, 8'h15, 8'h87, 1);
        check("stream_idle", 2'b00, 0, 0, 8'h15, 0);

        // mid-operation reset discards the held beat
        step(0, 2'b10, 8'h00, 8'hA5, 1);
        check("rst_grant", 2'b10, 1, 0, 8'h15, 0);
        step(0, 2'b10, 8'h00, 8'hA5, 0);
        check("rst_held", 2'b00, 1, 1, 8'hA5, 1);
        step(1, 2'b10, 8'h00, 8'hA5, 0);
        check("rst_clear", 2'b00, 0, 0, 8'h00, 0);
        step(0, 2'b00, 8'h00, 8'h00, 1);
        check("rst_idle", 2'b00, 0, 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
